sumador_serie: RTL and testbench

SUMADOR_SERIE -- requirements
Module: sumador_serie

---
 rtl/sumador_serie.sv | 140 ++++++++++++++
 tb/tb_sumador_serie.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serie.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB slice first.
// Result, carry and signed overflow are published together on completion.
module sumador_serie #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             v_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_capture;
  logic w_step;
  logic w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_amsb;
  logic             r_bmsb;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]         w_slice;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_acc_nxt;
  logic                   w_v;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_capture   = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          w_capture   = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_slice = {1'b0, r_a[DIGIT-1:0]}
                 + {1'b0, r_b[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};

  // New slice enters at the top; after N steps the LSB slice sits at bit 0.
  assign w_cat     = {w_slice[DIGIT-1:0], r_acc};
  assign w_acc_nxt = w_cat[WIDTH+DIGIT-1:DIGIT];

  // Same-sign operands with a differently-signed result means overflow.
  assign w_v = (r_amsb == r_bmsb) & (w_acc_nxt[WIDTH-1] ^ r_amsb);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
      r_cnt   <= '0;
      s_o     <= '0;
      c_o     <= 1'b0;
      v_o     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_a     <= a_i;
        r_b     <= sub_i ? ~b_i : b_i;
        r_acc   <= '0;
        r_carry <= c_i ^ sub_i;
        r_amsb  <= a_i[WIDTH-1];
        r_bmsb  <= b_i[WIDTH-1] ^ sub_i;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_acc   <= w_acc_nxt;
        r_carry <= w_slice[DIGIT];
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_last) begin
        s_o <= w_acc_nxt;
        c_o <= w_slice[DIGIT];
        v_o <= w_v;
      end
    end
  end

  assign busy_o = (r_state == RUN);
  assign done_o = (r_state == DONE);

endmodule

// File: tb/tb_sumador_serie.sv
// Scoreboard bench for sumador_serie (WIDTH=16, DIGIT=4).
// Stimulus pushes expectations; a negedge monitor pops them on done_o.
module tb_sumador_serie;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic [15:0] s_o;
  logic        c_o;
  logic        v_o;
  logic        busy_o;
  logic        done_o;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  sumador_serie #(.WIDTH(16), .DIGIT(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .c_i    (cin),
    .sub_i  (sub),
    .s_o    (s_o),
    .c_o    (c_o),
    .v_o    (v_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done_o), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("s_o", 32'(s_o), 32'(e.s));
        chk("c_o", 32'(c_o), 32'(e.c));
        chk("v_o", 32'(v_o), 32'(e.v));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push(input logic [15:0] s, input logic c, input logic v);
    exp_t e;
    e.s = s;
    e.c = c;
    e.v = v;
    e.cyc = cyc + 5;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'(0));
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic op(input logic [15:0] ia, input logic [15:0] ib,
                    input logic ic, input logic is,
                    input logic [15:0] es, input logic ec, input logic ev);
    a = ia;
    b = ib;
    cin = ic;
    sub = is;
    start = 1'b1;
    push(es, ec, ev);
    @(negedge clk);
    start = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    drain();
  endtask

  logic [15:0] bb_a[3] = '{16'h1111, 16'hF000, 16'h4000};
  logic [15:0] bb_b[3] = '{16'h2222, 16'h1000, 16'h4000};
  logic [15:0] bb_s[3] = '{16'h3333, 16'h0000, 16'h8000};
  logic        bb_c[3] = '{1'b0, 1'b1, 1'b0};
  logic        bb_v[3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_s", 32'(s_o), 32'(0));
    chk("rst_c", 32'(c_o), 32'(0));
    chk("rst_v", 32'(v_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_done", 32'(done_o), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
    op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start during RUN is ignored; s_o holds the previous result
    a = 16'h0001;
    b = 16'h0001;
    cin = 1'b0;
    sub = 1'b0;
    start = 1'b1;
    push(16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    chk("hold_s_run1", 32'(s_o), 32'h7FFF);
    chk("busy_run", 32'(busy_o), 32'(1));
    @(negedge clk);
    chk("hold_s_run2", 32'(s_o), 32'h7FFF);
    drain();

    // start held high: done every 5th cycle, busy low only then
    for (int i = 0; i < 3; i++) begin
      a = bb_a[i];
      b = bb_b[i];
      cin = 1'b0;
      sub = 1'b0;
      start = 1'b1;
      push(bb_s[i], bb_c[i], bb_v[i]);
      for (int j = 1; j <= 5; j++) begin
        @(negedge clk);
        if (j == 1) begin
          a = 16'hFFFF;
          b = 16'hFFFF;
          if (i == 2) start = 1'b0;
        end
        chk($sformatf("b2b_done_%0d_%0d", i, j), 32'(done_o),
            32'(j == 5));
        chk($sformatf("b2b_busy_%0d_%0d", i, j), 32'(busy_o),
            32'(j != 5));
      end
    end
    drain();

    // reset mid-RUN aborts without a done pulse
    a = 16'h0AAA;
    b = 16'h0555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_s", 32'(s_o), 32'(0));
    chk("abort_c", 32'(c_o), 32'(0));
    chk("abort_v", 32'(v_o), 32'(0));
    chk("abort_busy", 32'(busy_o), 32'(0));
    chk("abort_done", 32'(done_o), 32'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_busy", 32'(busy_o), 32'(0));

    op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
